// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: PC-triggered capture FIFO snooping the CPU's pc, instruction, write-back data and flags.
// Define TRACE_TSTAMP_EN to append a TS_W-bit arm-relative timestamp as the LSB field of every entry.
module cpu_trace_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
`ifdef TRACE_TSTAMP_EN
    ,
    parameter int TS_W   = 16
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          pc,
    input  logic [DATA_W-1:0]          instr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [4:0]                 flags,
    input  logic                       arm,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic [4:0]                 event_mask,
    input  logic [CNT_W-1:0]           cap_limit,
    input  logic                       rd_en,
    output logic                       rd_valid,
`ifdef TRACE_TSTAMP_EN
    output logic [3*DATA_W+5+TS_W-1:0] rd_data,
`else
    output logic [3*DATA_W+4:0]        rd_data,
`endif
    output logic [CNT_W-1:0]           count,
    output logic [1:0]                 state,
    output logic                       overflow,
    output logic                       done
);

`ifdef TRACE_TSTAMP_EN
    localparam int ENTRY_W = 3*DATA_W + 5 + TS_W;
`else
    localparam int ENTRY_W = 3*DATA_W + 5;
`endif
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             st;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cap_cnt;
    logic [CNT_W-1:0]   cap_lim;
    logic [CNT_W-1:0]   cap_next;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] entry;

    logic qualify;
    logic trig_hit;
    logic want_wr;
    logic full;
    logic do_wr;
    logic do_rd;
    logic hit_lim;

    assign state = st;

    // Read handshake: rd_en is a pop request with no back-pressure. A request against a
    // non-empty FIFO returns the head entry one cycle later with rd_valid high; a request
    // against an empty FIFO yields rd_valid low and leaves rd_data unchanged.
    always_comb begin
        qualify  = (event_mask == 5'd0) || ((flags & event_mask) != 5'd0);
        trig_hit = (st == ARMED) && (pc == trig_pc);
        want_wr  = trig_hit || ((st == CAPTURE) && qualify);
        full     = (count == CNT_W'(DEPTH));
        do_wr    = !clear && want_wr && !full;
        do_rd    = !clear && rd_en && (count != '0);
        cap_next = cap_cnt + CNT_W'(1);
        hit_lim  = do_wr && (cap_next == cap_lim);
    end

`ifdef TRACE_TSTAMP_EN
    logic [TS_W-1:0] ts;

    // Loading 1 makes the arm cycle itself stamp 0, so a stamp is the distance from arm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else if (arm && (st == IDLE) && !clear) begin
            ts <= TS_W'(1);
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    assign entry = {pc, instr, wdata, flags, ts};
`else
    assign entry = {pc, instr, wdata, flags};
`endif

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cap_cnt  <= '0;
            cap_lim  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else if (clear) begin
            st       <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cap_cnt  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Fullness is judged before the same-cycle pop, so a pop never rescues a write.
            if (do_wr) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                cap_cnt <= cap_next;
            end else if (want_wr && full) begin
                overflow <= 1'b1;
            end

            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= do_rd;
            count    <= count + CNT_W'(do_wr) - CNT_W'(do_rd);

            case (st)
                IDLE: begin
                    if (arm) begin
                        st      <= ARMED;
                        cap_cnt <= '0;
                        cap_lim <= (cap_limit == '0) ? CNT_W'(DEPTH) : cap_limit;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        if (hit_lim) begin
                            st   <= DONE;
                            done <= 1'b1;
                        end else begin
                            st <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (hit_lim) begin
                        st   <= DONE;
                        done <= 1'b1;
                    end
                end
                default: begin
                    st <= DONE;
                end
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        count <= CNT_W'(DEPTH));
    a_done_state: assert property (@(posedge clk) disable iff (!reset)
        done == (st == DONE));
    a_ptr_gap: assert property (@(posedge clk) disable iff (!reset)
        (wr_ptr - rd_ptr) == count[PTR_W-1:0]);

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: randomized and directed stimulus against a queue-based model of the trace buffer.
// Build with TRACE_TSTAMP_EN defined to also cover the timestamp field.
module tb_cpu_trace_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef TRACE_TSTAMP_EN
    localparam int TS_W    = 16;
    localparam int ENTRY_W = 3*DATA_W + 5 + TS_W;
`else
    localparam int ENTRY_W = 3*DATA_W + 5;
`endif

    localparam int S_IDLE    = 0;
    localparam int S_ARMED   = 1;
    localparam int S_CAPTURE = 2;
    localparam int S_DONE    = 3;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               reset;
    logic [DATA_W-1:0]  pc, instr, wdata, trig_pc;
    logic [4:0]         flags, event_mask;
    logic               arm, clear, rd_en;
    logic [CNT_W-1:0]   cap_limit;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;
    logic [CNT_W-1:0]   count;
    logic [1:0]         state;
    logic               overflow, done;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .wdata      (wdata),
        .flags      (flags),
        .arm        (arm),
        .clear      (clear),
        .trig_pc    (trig_pc),
        .event_mask (event_mask),
        .cap_limit  (cap_limit),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .count      (count),
        .state      (state),
        .overflow   (overflow),
        .done       (done)
    );

    // ---------------- reference model and scoreboard ----------------
    logic [ENTRY_W-1:0] fifo_q[$];
    logic [ENTRY_W-1:0] exp_q[$];
    logic [ENTRY_W-1:0] last_data = '0;
    int  mode      = S_IDLE;
    int  captured  = 0;
    int  limit     = 0;
    bit  ovf       = 1'b0;
    bit  exp_valid = 1'b0;
    int  cyc       = 0;
    int  arm_cyc   = 0;
    int  n_cmp     = 0;
    int  n_bad     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] make_entry();
`ifdef TRACE_TSTAMP_EN
        return {pc, instr, wdata, flags, TS_W'(cyc - arm_cyc)};
`else
        return {pc, instr, wdata, flags};
`endif
    endfunction

    task automatic model_reset();
        mode      = S_IDLE;
        captured  = 0;
        limit     = 0;
        ovf       = 1'b0;
        exp_valid = 1'b0;
        last_data = '0;
        fifo_q.delete();
        exp_q.delete();
    endtask

    // One clock edge of the buffer's rules, applied to the inputs held across that edge.
    task automatic model_edge();
        logic [ENTRY_W-1:0] e;
        bit qual, wr, was_full, wrote;
        if (clear) begin
            mode      = S_IDLE;
            captured  = 0;
            ovf       = 1'b0;
            exp_valid = 1'b0;
            fifo_q.delete();
            return;
        end
        qual     = (event_mask == 5'd0) || ((flags & event_mask) != 5'd0);
        wr       = (mode == S_ARMED && pc == trig_pc) || (mode == S_CAPTURE && qual);
        was_full = (fifo_q.size() == DEPTH);
        exp_valid = 1'b0;
        if (rd_en && fifo_q.size() > 0) begin
            e = fifo_q.pop_front();
            exp_q.push_back(e);
            last_data = e;
            exp_valid = 1'b1;
        end
        wrote = 1'b0;
        if (wr) begin
            if (was_full) begin
                ovf = 1'b1;
            end else begin
                fifo_q.push_back(make_entry());
                captured++;
                wrote = 1'b1;
            end
        end
        case (mode)
            S_IDLE: if (arm) begin
                mode     = S_ARMED;
                limit    = (cap_limit == '0) ? DEPTH : int'(cap_limit);
                captured = 0;
                arm_cyc  = cyc;
            end
            S_ARMED: if (pc == trig_pc) mode = (wrote && captured == limit) ? S_DONE : S_CAPTURE;
            S_CAPTURE: if (wrote && captured == limit) mode = S_DONE;
            default: ;
        endcase
    endtask

    // Monitor: compares every output against the model, popping expected reads as they appear.
    always @(negedge clk) begin : monitor
        logic [ENTRY_W-1:0] e;
        check("rd_valid", 64'(rd_valid), 64'(exp_valid));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_data: got %0h with no read expected", rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(e));
            end
        end else begin
            exp_q.delete();
            check("rd_hold", 64'(rd_data), 64'(last_data));
        end
        check("count",    64'(count),    64'(fifo_q.size()));
        check("state",    64'(state),    64'(mode));
        check("overflow", 64'(overflow), 64'(ovf));
        check("done",     64'(done),     64'(mode == S_DONE));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        arm   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic drive_random_data();
        instr = 8'($urandom);
        wdata = 8'($urandom);
        flags = 5'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #2;
        check("rst_state",    64'(state),    64'(S_IDLE));
        check("rst_count",    64'(count),    64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_data",  64'(rd_data),  64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_done",     64'(done),     64'(0));
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic arm_with(input logic [DATA_W-1:0] tpc, input logic [4:0] mask,
                            input logic [CNT_W-1:0] lim);
        trig_pc    = tpc;
        event_mask = mask;
        cap_limit  = lim;
        pc         = tpc + 8'h80;
        arm        = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        {pc, instr, wdata, trig_pc, flags, event_mask} = '0;
        {arm, clear, rd_en} = '0;
        cap_limit = '0;
        #1;
        do_reset();

        // Reset in the middle of a capture with five entries held.
        arm_with(8'h30, 5'd0, '0);
        pc = 8'h30;
        drive_random_data();
        tick();
        for (int i = 0; i < 4; i++) begin
            pc = pc + 8'h01;
            drive_random_data();
            tick();
        end
        check("pre_rst_count", 64'(count), 64'(5));
        do_reset();
        rd_en = 1'b1;
        tick();
        check("post_rst_rd_valid", 64'(rd_valid), 64'(0));
        rd_en = 1'b0;

        // Trigger at 0x04 with a limit of three on a PC stepping by two.
        arm_with(8'h04, 5'd0, CNT_W'(3));
        for (int k = 0; k < 6; k++) begin
            pc = 8'(2 * k);
            drive_random_data();
            tick();
        end
        check("lim3_count", 64'(count), 64'(3));
        check("lim3_done",  64'(done),  64'(1));
        rd_en = 1'b1;
        tick();
        check("lim3_first_pc", 64'(rd_data[ENTRY_W-1 -: DATA_W]), 64'(8'h04));
        tick();
        check("lim3_second_pc", 64'(rd_data[ENTRY_W-1 -: DATA_W]), 64'(8'h06));
        rd_en = 1'b0;

        // clear and arm together in DONE: clear wins.
        clear = 1'b1;
        arm   = 1'b1;
        tick();
        check("clr_arm_state",    64'(state),    64'(S_IDLE));
        check("clr_arm_count",    64'(count),    64'(0));
        check("clr_arm_overflow", 64'(overflow), 64'(0));

        // RegWrite-only qualification, unlimited capture.
        arm_with(8'h10, 5'b00010, '0);
        pc = 8'h10;
        drive_random_data();
        tick();
        for (int k = 0; k < 6; k++) begin
            pc = 8'h11 + 8'(k);
            drive_random_data();
            flags = (k == 1 || k == 4) ? (flags | 5'b00010) : (flags & 5'b11101);
            tick();
        end
        check("regwr_count", 64'(count), 64'(3));
        check("regwr_state", 64'(state), 64'(S_CAPTURE));
        clear = 1'b1;
        tick();

        // Fill past DEPTH without reads; limit above DEPTH keeps the capture running.
        arm_with(8'h20, 5'd0, CNT_W'(31));
        pc = 8'h20;
        for (int k = 0; k < 20; k++) begin
            drive_random_data();
            tick();
            pc = pc + 8'h01;
        end
        check("full_count",    64'(count),    64'(DEPTH));
        check("full_overflow", 64'(overflow), 64'(1));
        check("full_state",    64'(state),    64'(S_CAPTURE));
        rd_en = 1'b1;
        drive_random_data();
        tick();
        check("full_pushpop_count", 64'(count),    64'(DEPTH - 1));
        check("full_pushpop_ovf",   64'(overflow), 64'(1));
        event_mask = 5'b10000;
        flags      = 5'b00000;
        for (int k = 0; k < DEPTH - 5; k++) tick();
        check("drain_count", 64'(count), 64'(4));
        event_mask = 5'd0;
        drive_random_data();
        tick();
        check("mid_pushpop_count", 64'(count), 64'(4));
        event_mask = 5'b10000;
        flags      = 5'b00000;
        for (int k = 0; k < 5; k++) tick();
        rd_en = 1'b0;
        clear = 1'b1;
        tick();

`ifdef TRACE_TSTAMP_EN
        // Trigger seven cycles after arm: first entry carries stamp 7.
        arm_with(8'h40, 5'd0, CNT_W'(2));
        for (int k = 0; k < 6; k++) begin
            pc = 8'h41;
            tick();
        end
        pc = 8'h40;
        tick();
        rd_en = 1'b1;
        tick();
        check("ts_first", 64'(rd_data[TS_W-1:0]), 64'(7));
        rd_en = 1'b0;
        clear = 1'b1;
        tick();
`endif

        // Randomized phase: small PC range so triggers are frequent; read rate varies by segment.
        for (int i = 0; i < 2400; i++) begin
            if (i == 1200) do_reset();
            pc = 8'($urandom_range(0, 15));
            drive_random_data();
            if ($urandom_range(0, 30) == 0) begin
                trig_pc    = 8'($urandom_range(0, 15));
                event_mask = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
                cap_limit  = CNT_W'($urandom);
            end
            rd_en = (((i / 200) % 2) == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            arm   = ($urandom_range(0, 9) == 0);
            clear = ($urandom_range(0, 80) == 0);
            tick();
        end

        rd_en = 1'b0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
